mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and round-robin arbiter that shares the CPU's single-port synchronous memory between the instruction-fetch path, the data (load/store) path and an optional debug/loader port. It sits between the control/datapath and the memory macro and serialises every access through a fixed four-state sequence. Each access has a req/ack handshake, a registered read-data return and a one-cycle acknowledge pulse.

## Interface
- AW, 5, memory address width (words)
- DW, 8, memory data width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  instruction-fetch read request
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DW  registered fetch data
- da_req  in  1  data-path request
- da_we  in  1  1 = store, 0 = load
- da_addr  in  AW  data address
- da_wdata  in  DW  store data
- da_ack  out  1  one-cycle completion pulse
- da_rdata  out  DW  registered load data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/AW/DW  debug/loader request, same meaning as da_*
- dbg_ack  out  1  debug completion pulse
- dbg_rdata  out  DW  registered debug read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after mem_en
- busy  out  1  high whenever state != IDLE
- grant_id  out  2  0 = if, 1 = da, 2 = dbg, 3 = none

## Operation
- States: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE. No other transitions except reset.
- IDLE:
  - If any enabled req is high, select a winner by round-robin over the order if(0), da(1), dbg(2).
  - Search starts at last_gnt+1 mod N.
  - Latch the winner's addr, we and wdata; fetch latches we = 0. Set grant_id. Go to ISSUE.
  - With no request, stay in IDLE with grant_id = 3.
- ISSUE: mem_en = 1; mem_we, mem_addr and mem_wdata are driven from the latched values.
- CAPTURE: mem_en = 0. On a read, the winner's rdata register loads mem_rdata at the end of the cycle. On a write, rdata is unchanged.
- ACK:
  - The winner's ack = 1 for exactly this cycle; the rdata register already holds the new value.
  - last_gnt updates to the winner; next state is IDLE.
  - No arbitration happens in ACK.
- Requester rules:
  - Hold req high until ack.
  - addr/we/wdata only need to be valid in the IDLE cycle where req is sampled.
  - Dropping req before ack does not cancel the access; ack still pulses.
  - req still high in the cycle after ACK is treated as a new access.
- Only one ack is high in any cycle. Acks of different requesters never overlap.
- mem_we is high only when mem_en is high.
- Outputs are registered or decoded from state and latched registers; no req-to-mem combinational path.

## Timing
- Reset values:
  - state = IDLE; all acks, mem_en and mem_we = 0.
  - mem_addr, mem_wdata and all rdata = 0.
  - busy = 0; grant_id = 3.
  - last_gnt = highest enabled index (2 with debug, 1 without), so if wins first.
- Latency: req sampled in IDLE at cycle t; mem_en in t+1; mem_rdata captured at end of t+2; ack and valid rdata in t+3.
- Earliest next grant is t+4. Throughput is one access per 4 cycles.
- Simultaneous requests in IDLE are resolved purely by round-robin. With continuous contention, each requester wins at least once every N accesses.
- rst during any state:
  - Next cycle is IDLE with reset values.
  - The in-flight access is aborted with no ack; a write already strobed in ISSUE may have reached memory.
  - Requesters must re-request.
- Address and data are not modified; no wrap or width arithmetic. The round-robin pointer wraps N-1 -> 0.

## Configuration
- MEM_ARB_DBG_EN defined:
  - The debug port participates as requester 2.
  - Round-robin is 3-way; last_gnt resets to 2.
- MEM_ARB_DBG_EN undefined:
  - dbg_* inputs are ignored; dbg_ack = 0 and dbg_rdata = 0 always.
  - Round-robin is 2-way (if, da); last_gnt resets to 1.
  - grant_id never equals 2.

## Test plan
- Reset: hold rst 2 cycles with all reqs high -> all acks 0, mem_en 0, busy 0, grant_id 3. First grant after release goes to if.
- Single fetch, mem[5] = 0xA3: if_req with if_addr = 5 at t -> mem_en = 1, mem_we = 0, mem_addr = 5 at t+1; if_ack = 1 and if_rdata = 0xA3 at t+3 only; busy high t+1..t+3.
- Store then fetch: da store addr 9, data 0x5C -> mem_we = 1 at t+1, da_ack at t+3, da_rdata unchanged. Then if read of addr 9 -> if_rdata = 0x5C.
- Contention: if_req and da_req held high from reset -> grants alternate if, da, if, da; acks arrive 4 cycles apart; no cycle has two acks.
- Three-way, MEM_ARB_DBG_EN defined: all reqs held high -> grant order if, da, dbg, if. Same stimulus with the macro undefined -> order if, da, if, da and dbg_ack stays 0.
- Reset mid-access: rst asserted in CAPTURE of an if read -> no if_ack; next cycle IDLE with if_rdata = 0 and mem_en = 0. After rst drops, a held if_req is re-granted and completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// path, the data (load/store) path and an optional debug/loader port.
// Every access walks the fixed sequence IDLE -> ISSUE -> CAPTURE -> ACK,
// and the winner of each IDLE cycle is picked round-robin.
// Optional feature: define MEM_ARB_DBG_EN to let the debug/loader port
// take part in arbitration as requester 2. Without it the dbg_* inputs
// are ignored and dbg_ack/dbg_rdata stay at zero.
module mem_arbiter #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   // instruction fetch (read only)
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   // data path
   input  logic          da_req,
   input  logic          da_we,
   input  logic [AW-1:0] da_addr,
   input  logic [DW-1:0] da_wdata,
   output logic          da_ack,
   output logic [DW-1:0] da_rdata,
   // debug / loader
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   // memory macro
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   // status
   output logic          busy,
   output logic [1:0]    grant_id
);

   localparam logic [1:0] ID_IF   = 2'd0;
   localparam logic [1:0] ID_DA   = 2'd1;
   localparam logic [1:0] ID_DBG  = 2'd2;
   localparam logic [1:0] ID_NONE = 2'd3;

`ifdef MEM_ARB_DBG_EN
   localparam int unsigned NREQ    = 3;
   localparam logic [1:0]  LAST_ID = ID_DBG;
`else
   localparam int unsigned NREQ    = 2;
   localparam logic [1:0]  LAST_ID = ID_DA;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_ACK
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   // round-robin pointer and the latched access of the current winner
   logic [1:0]    r_last_gnt;
   logic [1:0]    r_win;
   logic [1:0]    r_grant_id;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;

   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_da_rdata;

   logic [3:0]    w_req;
   logic          w_found;
   logic [1:0]    w_win;
   logic [1:0]    w_cand;
   logic          w_sel_we;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;
   logic          w_issue;
   logic          w_ack;

`ifdef MEM_ARB_DBG_EN
   logic [DW-1:0] r_dbg_rdata;
   assign w_req = {1'b0, dbg_req, da_req, if_req};
`else
   // debug port is not part of this build; its inputs are deliberately dropped
   logic          w_unused_dbg;
   assign w_unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_wdata};
   assign w_req = {1'b0, 1'b0, da_req, if_req};
`endif

   // round-robin search: walk the candidates starting after the last winner
   always_comb begin
      w_found = 1'b0;
      w_win   = ID_IF;
      w_cand  = r_last_gnt;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_cand = (w_cand == LAST_ID) ? ID_IF : w_cand + 2'd1;
         if (!w_found && w_req[w_cand]) begin
            w_found = 1'b1;
            w_win   = w_cand;
         end
      end
   end

   // select the winning requester's address, direction and write data
   always_comb begin
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      case (w_win)
         ID_IF: begin
            w_sel_addr = if_addr;
         end
         ID_DA: begin
            w_sel_we    = da_we;
            w_sel_addr  = da_addr;
            w_sel_wdata = da_wdata;
         end
`ifdef MEM_ARB_DBG_EN
         ID_DBG: begin
            w_sel_we    = dbg_we;
            w_sel_addr  = dbg_addr;
            w_sel_wdata = dbg_wdata;
         end
`endif
         default: begin
            w_sel_we = 1'b0;
         end
      endcase
   end

   // next-state logic: the sequence never branches once an access is granted
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_found) w_state_nxt = ST_ISSUE;
         ST_ISSUE:   w_state_nxt = ST_CAPTURE;
         ST_CAPTURE: w_state_nxt = ST_ACK;
         ST_ACK:     w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // state register, access latch, grant id and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_last_gnt <= LAST_ID;
         r_win      <= ID_IF;
         r_grant_id <= ID_NONE;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_found) begin
            r_win      <= w_win;
            r_grant_id <= w_win;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
         end
         if (r_state == ST_ACK) begin
            r_last_gnt <= r_win;
            r_grant_id <= ID_NONE;
         end
      end
   end

   // read data capture into the winner's return register at the end of CAPTURE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_if_rdata  <= '0;
         r_da_rdata  <= '0;
`ifdef MEM_ARB_DBG_EN
         r_dbg_rdata <= '0;
`endif
      end else if (r_state == ST_CAPTURE && !r_we) begin
         case (r_win)
            ID_IF: r_if_rdata <= mem_rdata;
            ID_DA: r_da_rdata <= mem_rdata;
`ifdef MEM_ARB_DBG_EN
            ID_DBG: r_dbg_rdata <= mem_rdata;
`endif
            default: ;
         endcase
      end
   end

   assign w_issue   = (r_state == ST_ISSUE);
   assign w_ack     = (r_state == ST_ACK);

   assign mem_en    = w_issue;
   assign mem_we    = w_issue & r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

   assign busy      = (r_state != ST_IDLE);
   assign grant_id  = r_grant_id;

   assign if_ack    = w_ack && (r_win == ID_IF);
   assign da_ack    = w_ack && (r_win == ID_DA);
   assign if_rdata  = r_if_rdata;
   assign da_rdata  = r_da_rdata;

`ifdef MEM_ARB_DBG_EN
   assign dbg_ack   = w_ack && (r_win == ID_DBG);
   assign dbg_rdata = r_dbg_rdata;
`else
   assign dbg_ack   = 1'b0;
   assign dbg_rdata = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A transaction-level reference model
// (grant cycle timestamps, round-robin by modular search, word array memory)
// predicts every output; each test task compares inline.
// Follows MEM_ARB_DBG_EN in the same way as the design.
module tb_mem_arbiter;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 8;
`ifdef MEM_ARB_DBG_EN
   localparam int N = 3;
`else
   localparam int N = 2;
`endif

   logic          clk;
   logic          rst;
   logic          if_req, da_req, da_we, dbg_req, dbg_we;
   logic [AW-1:0] if_addr, da_addr, dbg_addr;
   logic [DW-1:0] da_wdata, dbg_wdata;
   logic          if_ack, da_ack, dbg_ack;
   logic [DW-1:0] if_rdata, da_rdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy;
   logic [1:0]    grant_id;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .da_req(da_req), .da_we(da_we), .da_addr(da_addr), .da_wdata(da_wdata),
      .da_ack(da_ack), .da_rdata(da_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port synchronous memory macro, with a bench preload port
   logic [DW-1:0] mem [32];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state
   logic [DW-1:0] ref_mem [32];
   bit            m_act;
   int            m_t0, m_win, m_last;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rd [3];

   // expectations for the current cycle
   bit            e_busy, e_en, e_we;
   logic [1:0]    e_gid;
   logic [2:0]    e_ack;

   // advance the model with the inputs present in the current cycle
   task automatic model_sample();
      logic [2:0] r;
      r[0] = if_req;
      r[1] = da_req;
      r[2] = (N == 3) ? dbg_req : 1'b0;
      if (m_act && cyc == m_t0 + 1 && m_we) ref_mem[m_addr] = m_wdata;
      if (rst) begin
         m_act  = 0;
         m_last = N - 1;
         foreach (m_rd[i]) m_rd[i] = '0;
         return;
      end
      if (m_act && cyc == m_t0 + 2 && !m_we) m_rd[m_win] = ref_mem[m_addr];
      if (!m_act || cyc >= m_t0 + 4) begin
         m_act = 0;
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (r[idx] === 1'b1) begin
               m_act  = 1;
               m_t0   = cyc;
               m_win  = idx;
               m_last = idx;
               case (idx)
                  0: begin m_we = 0; m_addr = if_addr; m_wdata = '0; end
                  1: begin m_we = da_we; m_addr = da_addr; m_wdata = da_wdata; end
                  default: begin m_we = dbg_we; m_addr = dbg_addr; m_wdata = dbg_wdata; end
               endcase
               break;
            end
         end
      end
   endtask

   // one clock, then derive expectations from the grant timestamp
   task automatic tick();
      int ph;
      @(posedge clk);
      #1;
      cyc++;
      ph     = m_act ? cyc - m_t0 : 0;
      e_busy = m_act && ph >= 1 && ph <= 3;
      e_en   = m_act && ph == 1;
      e_we   = e_en && m_we;
      e_gid  = e_busy ? 2'(m_win) : 2'd3;
      e_ack  = '0;
      if (m_act && ph == 3) e_ack[m_win] = 1'b1;
   endtask

   task automatic step();
      model_sample();
      tick();
   endtask

   task automatic drop_reqs();
      if_req = 0; da_req = 0; dbg_req = 0;
   endtask

   task automatic settle();
      drop_reqs();
      rst = 0;
      for (int i = 0; i < 5; i++) step();
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1; pl_addr = a; pl_data = d;
      ref_mem[a] = d;
      step();
      pl_en = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      if_req = 1; da_req = 1; dbg_req = 1;
      da_we = 1; dbg_we = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({if_ack, da_ack, dbg_ack} !== 3'b000) begin
            errors++; $display("FAIL reset_acks: got %b expected 000", {if_ack, da_ack, dbg_ack});
         end
         checks++;
         if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got en=%b we=%b busy=%b expected 0 0 0", mem_en, mem_we, busy);
         end
         checks++;
         if (grant_id !== 2'd3) begin
            errors++; $display("FAIL reset_grant_id: got %0d expected 3", grant_id);
         end
         checks++;
         if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || da_rdata !== '0 || dbg_rdata !== '0) begin
            errors++; $display("FAIL reset_data: got addr=%h wd=%h ifr=%h dar=%h dbgr=%h expected all 0",
                               mem_addr, mem_wdata, if_rdata, da_rdata, dbg_rdata);
         end
      end
      rst = 0;
      step();
      checks++;
      if (grant_id !== 2'd0 || mem_en !== 1'b1) begin
         errors++; $display("FAIL reset_first_grant: got gid=%0d en=%b expected gid=0 en=1", grant_id, mem_en);
      end
      settle();
   endtask

   task automatic test_single_fetch();
      preload(5'd5, 8'hA3);
      if_req = 1; if_addr = 5'd5;
      step();
      if_req = 0; if_addr = 5'($urandom);
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd5 || busy !== 1'b1 || grant_id !== 2'd0) begin
         errors++; $display("FAIL fetch_issue: got en=%b we=%b addr=%0d busy=%b gid=%0d expected 1 0 5 1 0",
                            mem_en, mem_we, mem_addr, busy, grant_id);
      end
      step();
      checks++;
      if (mem_en !== 1'b0 || busy !== 1'b1 || if_ack !== 1'b0) begin
         errors++; $display("FAIL fetch_capture: got en=%b busy=%b ack=%b expected 0 1 0", mem_en, busy, if_ack);
      end
      step();
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 8'hA3 || busy !== 1'b1) begin
         errors++; $display("FAIL fetch_ack: got ack=%b rdata=%h busy=%b expected 1 a3 1", if_ack, if_rdata, busy);
      end
      step();
      checks++;
      if (if_ack !== 1'b0 || busy !== 1'b0 || if_rdata !== 8'hA3) begin
         errors++; $display("FAIL fetch_after: got ack=%b busy=%b rdata=%h expected 0 0 a3", if_ack, busy, if_rdata);
      end
      settle();
   endtask

   task automatic test_store_fetch();
      logic [DW-1:0] old_rd;
      old_rd = m_rd[1];
      da_req = 1; da_we = 1; da_addr = 5'd9; da_wdata = 8'h5C;
      step();
      da_req = 0; da_addr = 5'($urandom); da_wdata = 8'($urandom);
      checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 5'd9 || mem_wdata !== 8'h5C || grant_id !== 2'd1) begin
         errors++; $display("FAIL store_issue: got en=%b we=%b addr=%0d wd=%h gid=%0d expected 1 1 9 5c 1",
                            mem_en, mem_we, mem_addr, mem_wdata, grant_id);
      end
      step();
      step();
      checks++;
      if (da_ack !== 1'b1 || if_ack !== 1'b0 || da_rdata !== old_rd) begin
         errors++; $display("FAIL store_ack: got ack=%b if_ack=%b rdata=%h expected 1 0 %h", da_ack, if_ack, da_rdata, old_rd);
      end
      step();
      if_req = 1; if_addr = 5'd9;
      step();
      if_req = 0;
      step();
      step();
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 8'h5C) begin
         errors++; $display("FAIL store_then_fetch: got ack=%b rdata=%h expected 1 5c", if_ack, if_rdata);
      end
      settle();
   endtask

   // all listed requesters held high from reset; grant order and ack spacing
   task automatic test_contention(input bit with_dbg, input int n_acc, input string tag);
      int obs[$];
      int ack_at[$];
      int exp_id;
      obs = {};
      ack_at = {};
      rst = 1;
      if_req = 1; da_req = 1; dbg_req = with_dbg; da_we = 0; dbg_we = 0;
      step();
      rst = 0;
      for (int i = 0; i < 4 * n_acc; i++) begin
         if_addr = 5'($urandom); da_addr = 5'($urandom); dbg_addr = 5'($urandom);
         step();
         if (mem_en === 1'b1) obs.push_back(int'(grant_id));
         if ((if_ack | da_ack | dbg_ack) === 1'b1) ack_at.push_back(cyc);
         checks++;
         if ({dbg_ack, da_ack, if_ack} !== e_ack || grant_id !== e_gid) begin
            errors++; $display("FAIL %s_cycle cyc=%0d: got acks=%b gid=%0d expected acks=%b gid=%0d",
                               tag, cyc, {dbg_ack, da_ack, if_ack}, grant_id, e_ack, e_gid);
         end
         checks++;
         if ($countones({if_ack, da_ack, dbg_ack}) > 1) begin
            errors++; $display("FAIL %s_overlap cyc=%0d: got acks=%b expected at most one", tag, cyc, {dbg_ack, da_ack, if_ack});
         end
      end
      checks++;
      if (obs.size() != n_acc || ack_at.size() != n_acc) begin
         errors++; $display("FAIL %s_count: got grants=%0d acks=%0d expected %0d", tag, obs.size(), ack_at.size(), n_acc);
      end else begin
         for (int i = 0; i < n_acc; i++) begin
            exp_id = (with_dbg && N == 3) ? i % 3 : i % 2;
            checks++;
            if (obs[i] != exp_id) begin
               errors++; $display("FAIL %s_order[%0d]: got %0d expected %0d", tag, i, obs[i], exp_id);
            end
            if (i > 0) begin
               checks++;
               if (ack_at[i] - ack_at[i-1] != 4) begin
                  errors++; $display("FAIL %s_spacing[%0d]: got %0d expected 4", tag, i, ack_at[i] - ack_at[i-1]);
               end
            end
         end
      end
      settle();
   endtask

   task automatic test_reset_mid();
      preload(5'd17, 8'h3C);
      if_req = 1; if_addr = 5'd17;
      step();
      step();
      rst = 1;
      step();
      checks++;
      if (if_ack !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || grant_id !== 2'd3 || if_rdata !== '0) begin
         errors++; $display("FAIL midrst_abort: got ack=%b busy=%b en=%b gid=%0d rdata=%h expected 0 0 0 3 00",
                            if_ack, busy, mem_en, grant_id, if_rdata);
      end
      rst = 0;
      step();
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== 5'd17 || grant_id !== 2'd0) begin
         errors++; $display("FAIL midrst_regrant: got en=%b addr=%0d gid=%0d expected 1 17 0", mem_en, mem_addr, grant_id);
      end
      step();
      step();
      checks++;
      if (if_ack !== 1'b1 || if_rdata !== 8'h3C) begin
         errors++; $display("FAIL midrst_complete: got ack=%b rdata=%h expected 1 3c", if_ack, if_rdata);
      end
      settle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         if_req    = ($urandom_range(0, 9) < 5);
         da_req    = ($urandom_range(0, 9) < 5);
         dbg_req   = ($urandom_range(0, 9) < 4);
         da_we     = 1'($urandom);
         dbg_we    = 1'($urandom);
         if_addr   = 5'($urandom);
         da_addr   = 5'($urandom);
         dbg_addr  = 5'($urandom);
         da_wdata  = 8'($urandom);
         dbg_wdata = 8'($urandom);
         step();
         checks++;
         if (busy !== e_busy || mem_en !== e_en || mem_we !== e_we || grant_id !== e_gid) begin
            errors++; $display("FAIL rand_ctrl cyc=%0d: got busy=%b en=%b we=%b gid=%0d expected %b %b %b %0d",
                               cyc, busy, mem_en, mem_we, grant_id, e_busy, e_en, e_we, e_gid);
         end
         checks++;
         if ({dbg_ack, da_ack, if_ack} !== e_ack) begin
            errors++; $display("FAIL rand_ack cyc=%0d: got %b expected %b", cyc, {dbg_ack, da_ack, if_ack}, e_ack);
         end
         checks++;
         if (if_rdata !== m_rd[0] || da_rdata !== m_rd[1] || dbg_rdata !== m_rd[2]) begin
            errors++; $display("FAIL rand_rdata cyc=%0d: got %h %h %h expected %h %h %h",
                               cyc, if_rdata, da_rdata, dbg_rdata, m_rd[0], m_rd[1], m_rd[2]);
         end
         if (e_en) begin
            checks++;
            if (mem_addr !== m_addr || (m_we && mem_wdata !== m_wdata)) begin
               errors++; $display("FAIL rand_mem cyc=%0d: got addr=%h wd=%h expected addr=%h wd=%h",
                                  cyc, mem_addr, mem_wdata, m_addr, m_wdata);
            end
         end
      end
      settle();
   endtask

   initial begin
      rst = 1; pl_en = 0; pl_addr = '0; pl_data = '0;
      if_req = 0; da_req = 0; dbg_req = 0; da_we = 0; dbg_we = 0;
      if_addr = '0; da_addr = '0; dbg_addr = '0; da_wdata = '0; dbg_wdata = '0;
      m_act = 0; m_t0 = 0; m_win = 0; m_last = N - 1;
      m_we = 0; m_addr = '0; m_wdata = '0;
      foreach (m_rd[i]) m_rd[i] = '0;
      for (int a = 0; a < 32; a++) preload(5'(a), 8'($urandom));
      test_reset();
      test_single_fetch();
      test_store_fetch();
      test_contention(1'b0, 4, "contention");
      test_contention(1'b1, 6, "three_way");
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
